// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream and writes 16-bit instruction
// words into instruction memory while holding the CPU in reset.
// Frame: SYNC_BYTE, word count N (0 means 256), N x {high byte, low byte},
// then an XOR checksum byte when LOADER_CHECKSUM_EN is defined.
// Without LOADER_CHECKSUM_EN the checksum state and accumulator are absent
// and err is tied low.
module imem_loader #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        abort,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4,
        S_CSUM  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_WRITE = 3'd4
    } state_t;
`endif

    state_t      state_q,    state_d;
    logic        in_ready_q, in_ready_d;
    logic        wr_en_q,    wr_en_d;
    logic [7:0]  wr_addr_q,  wr_addr_d;
    logic [15:0] wr_data_q,  wr_data_d;
    logic [7:0]  hi_q,       hi_d;
    // Address of the next word to be written; wr_addr only changes when a
    // complete word is ready so it stays stable between writes.
    logic [7:0]  addr_q,     addr_d;
    // Words remaining; 9 bits so a count byte of 0 can represent 256.
    logic [8:0]  cnt_q,      cnt_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q,     done_d;
`ifdef LOADER_CHECKSUM_EN
    logic        err_q,      err_d;
    logic [7:0]  acc_q,      acc_d;
`endif

    logic        xfer;

    assign xfer = in_valid & in_ready_q;

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        hi_d       = hi_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
`ifdef LOADER_CHECKSUM_EN
        err_d      = err_q;
        acc_d      = acc_q;
`endif
        if (abort && (state_q != S_IDLE)) begin
            // Cancel wins over any byte offered in the same cycle; leaving
            // LO here is what keeps the pending write from happening.
            state_d    = S_IDLE;
            cpu_hold_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer && (in_data == SYNC_BYTE)) begin
                        state_d    = S_COUNT;
                        cpu_hold_d = 1'b1;
                        done_d     = 1'b0;
                        addr_d     = START_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        err_d      = 1'b0;
                        acc_d      = 8'h00;
`endif
                    end
                end
                S_COUNT: begin
                    if (xfer) begin
                        cnt_d   = {(in_data == 8'h00), in_data};
                        state_d = S_HI;
`ifdef LOADER_CHECKSUM_EN
                        acc_d   = acc_q ^ in_data;
`endif
                    end
                end
                S_HI: begin
                    if (xfer) begin
                        hi_d    = in_data;
                        state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
                        acc_d   = acc_q ^ in_data;
`endif
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        wr_data_d = {hi_q, in_data};
                        wr_addr_d = addr_q;
                        state_d   = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                        acc_d     = acc_q ^ in_data;
`endif
                    end
                end
                S_WRITE: begin
                    addr_d = addr_q + 8'd1;
                    cnt_d  = cnt_q - 9'd1;
                    if (cnt_q != 9'd1) begin
                        state_d = S_HI;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state_d    = S_CSUM;
`else
                        state_d    = S_IDLE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        err_d      = (in_data != acc_q);
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
`endif
                default: begin
                    state_d    = S_IDLE;
                    cpu_hold_d = 1'b0;
                end
            endcase
        end
        // Strobes are registered from the next state so they line up with
        // the cycle spent in WRITE.
        wr_en_d    = (state_d == S_WRITE);
        in_ready_d = (state_d != S_WRITE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= START_ADDR;
            wr_data_q  <= 16'h0000;
            hi_q       <= 8'h00;
            addr_q     <= 8'h00;
            cnt_q      <= 9'h000;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            err_q      <= 1'b0;
            acc_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            hi_q       <= hi_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
`ifdef LOADER_CHECKSUM_EN
            err_q      <= err_d;
            acc_q      <= acc_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven frames, hand-written corner
// sequences (latency, abort, reset mid-frame, 256-word wrap) and random
// frames checked against a frame-level reference model. A second instance
// with START_ADDR=8'hFF shares the input stream to exercise address wrap.
module tb_imem_loader;

    localparam logic [7:0] SYNC   = 8'hA5;
    localparam logic [7:0] START2 = 8'hFF;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        bit          has_pre;
        logic [7:0]  pre;
        logic [7:0]  n;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [7:0]  csum;
        int          nw;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic [7:0]  a1;
        logic [15:0] d1;
        bit          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        abort;

    logic        in_ready1, wr_en1, cpu_hold1, done1, err1;
    logic [7:0]  wr_addr1;
    logic [15:0] wr_data1;
    logic        in_ready2, wr_en2, cpu_hold2, done2, err2;
    logic [7:0]  wr_addr2;
    logic [15:0] wr_data2;

    int n_chk  = 0;
    int n_fail = 0;
    bit gap_en = 1'b0;

    wr_t log1[$];
    wr_t log2[$];
    wr_t exp1[$];
    wr_t exp2[$];
    logic [15:0] frame_w [256];

    always #5 clk = ~clk;

    imem_loader #(.SYNC_BYTE(SYNC), .START_ADDR(8'h00)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .abort(abort), .wr_en(wr_en1), .wr_addr(wr_addr1),
        .wr_data(wr_data1), .cpu_hold(cpu_hold1), .done(done1), .err(err1)
    );

    imem_loader #(.SYNC_BYTE(SYNC), .START_ADDR(START2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .abort(abort), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_data(wr_data2), .cpu_hold(cpu_hold2), .done(done2), .err(err2)
    );

    // Capture every write strobe away from the active edge.
    always @(negedge clk) begin
        if (wr_en1) log1.push_back({wr_addr1, wr_data1});
        if (wr_en2) log2.push_back({wr_addr2, wr_data2});
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    task automatic send(input logic [7:0] b);
        int g;
        if (gap_en && ($urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        g = 0;
        while (!in_ready1 && g < 8) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready1) chk("in_ready_timeout", {31'd0, in_ready1}, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!done1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("done_set", {31'd0, done1}, 32'd1);
        @(negedge clk);
    endtask

    // Reference model: frame i word k goes to START+k (mod 256); the
    // checksum is the XOR of the count and all payload bytes.
    task automatic run_frame(input bit has_pre, input logic [7:0] pre, input logic [7:0] n,
                             input logic [7:0] csum, output bit exp_err);
        int nw;
        logic [7:0] x;
        nw = (n == 8'h00) ? 256 : int'(n);
        x  = n;
        if (has_pre) send(pre);
        send(SYNC);
        send(n);
        for (int i = 0; i < nw; i++) begin
            send(frame_w[i][15:8]);
            send(frame_w[i][7:0]);
            x = x ^ frame_w[i][15:8] ^ frame_w[i][7:0];
            exp1.push_back({8'(i), frame_w[i]});
            exp2.push_back({START2 + 8'(i), frame_w[i]});
        end
`ifdef LOADER_CHECKSUM_EN
        send(csum);
        exp_err = (csum != x);
`else
        exp_err = 1'b0;
        if (csum == x) exp_err = 1'b0;
`endif
        idle();
        wait_done();
        chk("err", {31'd0, err1}, {31'd0, exp_err});
        chk("cpu_hold_end", {31'd0, cpu_hold1}, 32'd0);
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nwrites1"}, log1.size(), exp1.size());
        chk({tag, "_nwrites2"}, log2.size(), exp2.size());
        while (log1.size() > 0 && exp1.size() > 0) chk({tag, "_wr1"}, 32'(log1.pop_front()), 32'(exp1.pop_front()));
        while (log2.size() > 0 && exp2.size() > 0) chk({tag, "_wr2"}, 32'(log2.pop_front()), 32'(exp2.pop_front()));
        log1.delete(); log2.delete(); exp1.delete(); exp2.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready1}, 32'd1);
        chk({tag, "_wr_en"},    {31'd0, wr_en1},    32'd0);
        chk({tag, "_wr_addr"},  {24'd0, wr_addr1},  32'h00);
        chk({tag, "_wr_addr2"}, {24'd0, wr_addr2},  32'hFF);
        chk({tag, "_wr_data"},  {16'd0, wr_data1},  32'h0000);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold1}, 32'd0);
        chk({tag, "_done"},     {31'd0, done1},     32'd0);
        chk({tag, "_err"},      {31'd0, err1},      32'd0);
    endtask

    vec_t tbl [4];

    initial begin
        bit e;
        logic [7:0] cs;
        logic [7:0] nn;

        tbl[0] = '{1'b0, 8'h00, 8'h02, 16'h4800, 16'h4A0C, 8'h0C, 2, 8'h00, 16'h4800, 8'h01, 16'h4A0C, 1'b0};
        tbl[1] = '{1'b1, 8'h11, 8'h01, 16'h1234, 16'h0000, 8'h27, 1, 8'h00, 16'h1234, 8'h00, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 8'h01, 16'h1234, 16'h0000, 8'h00, 1, 8'h00, 16'h1234, 8'h00, 16'h0000, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 8'h01, 16'hFFFF, 16'h0000, 8'h01, 1, 8'h00, 16'hFFFF, 8'h00, 16'h0000, 1'b0};

        rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single-word frame: hold asserted, write one cycle after low byte.
        send(SYNC);
        send(8'h01);
        chk("cpu_hold_loading", {31'd0, cpu_hold1}, 32'd1);
        chk("done_cleared", {31'd0, done1}, 32'd0);
        send(8'h12);
        send(8'h34);
        chk("wr_en_before_lo", {31'd0, wr_en1}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("wr_en_latency", {31'd0, wr_en1}, 32'd1);
        chk("in_ready_write", {31'd0, in_ready1}, 32'd0);
        chk("wr_addr_lat", {24'd0, wr_addr1}, 32'h00);
        chk("wr_data_lat", {16'd0, wr_data1}, 32'h1234);
        @(negedge clk);
        chk("wr_en_one_cycle", {31'd0, wr_en1}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready1}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
        send(8'h27);
        idle();
`endif
        wait_done();
        exp1.push_back({8'h00, 16'h1234});
        exp2.push_back({8'hFF, 16'h1234});
        check_logs("latency");

        // Table-driven frames.
        for (int k = 0; k < 4; k++) begin
            bit xe;
            frame_w[0] = tbl[k].w0;
            frame_w[1] = tbl[k].w1;
            run_frame(tbl[k].has_pre, tbl[k].pre, tbl[k].n, tbl[k].csum, e);
`ifdef LOADER_CHECKSUM_EN
            xe = tbl[k].exp_err;
`else
            xe = 1'b0;
`endif
            chk("tbl_err", {31'd0, err1}, {31'd0, xe});
            chk("tbl_nwrites", log1.size(), tbl[k].nw);
            if (log1.size() > 0) chk("tbl_w0", 32'(log1[0]), {8'd0, tbl[k].a0, tbl[k].d0});
            if (tbl[k].nw > 1 && log1.size() > 1) chk("tbl_w1", 32'(log1[1]), {8'd0, tbl[k].a1, tbl[k].d1});
            check_logs("tbl");
        end

        // done holds in IDLE, and abort in IDLE changes nothing.
        repeat (5) @(negedge clk);
        chk("done_hold", {31'd0, done1}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_done", {31'd0, done1}, 32'd1);
        chk("abort_idle_ready", {31'd0, in_ready1}, 32'd1);

        // Abort on the cycle the low byte is offered.
        send(SYNC);
        send(8'h01);
        send(8'h12);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h34; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0;
        chk("abort_wr_en", {31'd0, wr_en1}, 32'd0);
        chk("abort_cpu_hold", {31'd0, cpu_hold1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_ready", {31'd0, in_ready1}, 32'd1);
        repeat (4) @(negedge clk);
        check_logs("abort");

        // Reset pulse after the high byte.
        send(SYNC);
        send(8'h02);
        send(8'h12);
        @(posedge clk);
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_logs("after_reset");
        frame_w[0] = 16'hBEEF; frame_w[1] = 16'hCAFE;
        run_frame(1'b0, 8'h00, 8'h02, 8'h02 ^ 8'hBE ^ 8'hEF ^ 8'hCA ^ 8'hFE, e);
        check_logs("post_reset_frame");

        // 256-word frame (count byte 0) wraps both address counters.
        for (int i = 0; i < 256; i++) frame_w[i] = 16'($urandom);
        cs = 8'h00;
        for (int i = 0; i < 256; i++) cs = cs ^ frame_w[i][15:8] ^ frame_w[i][7:0];
        run_frame(1'b0, 8'h00, 8'h00, cs, e);
        check_logs("full256");

        // Random frames with gaps, junk prefixes and good/bad checksums.
        gap_en = 1'b1;
        for (int f = 0; f < 12; f++) begin
            logic [7:0] pre;
            nn = 8'($urandom_range(1, 20));
            cs = nn;
            for (int i = 0; i < int'(nn); i++) begin
                frame_w[i] = 16'($urandom);
                cs = cs ^ frame_w[i][15:8] ^ frame_w[i][7:0];
            end
            if ($urandom_range(0, 1) == 1) cs = cs ^ 8'(1 << $urandom_range(0, 7));
            pre = 8'($urandom);
            if (pre == SYNC) pre = 8'h5A;
            run_frame($urandom_range(0, 1) == 1, pre, nn, cs, e);
            check_logs("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5: the frame start marker.
REQ-002 The block SHALL have parameter START_ADDR, default 8'h00: the first instruction-memory address written in each frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the byte source has in_data valid.
REQ-006 The block SHALL have port in_data, input, 8 bits: the incoming byte stream.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the loader accepts in_data this cycle.
REQ-008 The block SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-009 The block SHALL have port wr_en, output, 1 bit: one-cycle instruction-memory write strobe.
REQ-010 The block SHALL have port wr_addr, output, 8 bits: instruction-memory word address.
REQ-011 The block SHALL have port wr_data, output, 16 bits: instruction word to write.
REQ-012 The block SHALL have port cpu_hold, output, 1 bit: holds the CPU in reset while loading.
REQ-013 The block SHALL have port done, output, 1 bit: the last frame finished.
REQ-014 The block SHALL have port err, output, 1 bit: the last frame failed its checksum.

Function
REQ-015 A byte SHALL be transferred only on a cycle with in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in states IDLE, COUNT, HI, LO and CSUM, and 0 in WRITE.
REQ-017 Frame format: SYNC_BYTE; count N (8'h00 means 256 words); N pairs, each high byte then low byte; then a checksum byte when LOADER_CHECKSUM_EN is defined.
REQ-018 IDLE: a transferred byte equal to SYNC_BYTE SHALL move to COUNT, set cpu_hold=1, clear done and err, and load the address counter with START_ADDR; any other byte SHALL be dropped.
REQ-019 COUNT: a transferred byte SHALL load the word counter and move to HI.
REQ-020 HI: a transferred byte SHALL be latched as wr_data[15:8]; then move to LO.
REQ-021 LO: a transferred byte SHALL be latched as wr_data[7:0]; then move to WRITE.
REQ-022 WRITE (exactly 1 cycle): wr_en=1 with the current wr_addr and wr_data; the address SHALL increment modulo 256 (8'hFF wraps to 8'h00) and the word counter SHALL decrement.
REQ-023 Leaving WRITE: go to HI if words remain; otherwise go to CSUM when checksum is enabled, else to IDLE with done=1 and cpu_hold=0.
REQ-024 Latency: wr_en SHALL assert on the cycle after the low byte is transferred.
REQ-025 wr_en SHALL be 0 in every state other than WRITE.
REQ-026 wr_addr and wr_data SHALL hold their values between writes.
REQ-027 abort=1 SHALL force IDLE on the next edge, set cpu_hold=0, leave done=0, and suppress any pending write; abort SHALL take priority over a simultaneous byte transfer.
REQ-028 abort received in IDLE SHALL have no effect.
REQ-029 done and err SHALL hold until the next accepted SYNC_BYTE.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, in_ready=1, wr_en=0, wr_addr=START_ADDR, wr_data=16'h0000, cpu_hold=0, done=0, err=0, and both counters and the checksum accumulator to 0.
REQ-031 Reset mid-frame SHALL discard the frame, and no write SHALL occur after reset release until a new frame arrives.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: the block SHALL XOR-accumulate every count and payload byte; in CSUM, the transferred byte SHALL be compared with the accumulator, then the block SHALL go to IDLE with done=1, cpu_hold=0, and err=1 on mismatch.
REQ-033 Macro LOADER_CHECKSUM_EN undefined: the CSUM state and accumulator SHALL be absent and err SHALL be constant 0.

Verification
REQ-034 Bytes A5 02 48 00 4A 0C (checksum off) -> writes (00,4800) then (01,4A0C); done=1; cpu_hold 1 to 0.
REQ-035 Bytes 11 A5 01 12 34, in IDLE -> byte 11 dropped; one write (00,1234).
REQ-036 START_ADDR=8'hFF, frame of 2 words -> writes to addresses FF then 00.
REQ-037 abort asserted on the cycle the LO byte is transferred -> no wr_en; IDLE; cpu_hold=0; done=0.
REQ-038 LOADER_CHECKSUM_EN, A5 01 12 34 followed by checksum 27 -> err=0; followed by 00 instead -> err=1; done=1 in both cases.
REQ-039 rst_n pulsed low after the HI byte -> all outputs at reset values immediately; the following frame loads normally.
